// File: rtl/rx_cmd_pkg.sv
// Shared definitions for the UART command sequencer: opcodes, FSM states
// and the fixed register-file slots used for ALU operands.
package rx_cmd_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        OP_A,
        OP_B,
        ALU_FN
    } state_t;

    // States in which the ALU clock must already be running.
    function automatic logic is_alu_state(input state_t s);
        return (s == OP_A) || (s == OP_B) || (s == ALU_FN);
    endfunction

endpackage

// File: rtl/rx_cmd_ctrl_if.sv
// Byte stream from the UART receiver plus the register-file / ALU control
// bundle driven by the command sequencer.
interface rx_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0] RX_P_DATA;
    logic                  RX_D_VLD;
    logic                  RX_ERR;
    logic                  RF_WrEn;
    logic                  RF_RdEn;
    logic [ADDR_WIDTH-1:0] RF_Address;
    logic [DATA_WIDTH-1:0] RF_WrData;
    logic                  ALU_EN;
    logic [FUN_WIDTH-1:0]  ALU_FUN;
    logic                  CLK_GATE_EN;
    logic                  BUSY;
    logic                  CMD_ERR;

    // Receiver / environment side.
    modport master (
        output RX_P_DATA, RX_D_VLD, RX_ERR,
        input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
        input  ALU_EN, ALU_FUN, CLK_GATE_EN, BUSY, CMD_ERR
    );

    // Sequencer side.
    modport slave (
        input  RX_P_DATA, RX_D_VLD, RX_ERR,
        output RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
        output ALU_EN, ALU_FUN, CLK_GATE_EN, BUSY, CMD_ERR
    );
endinterface

// File: rtl/rx_cmd_ctrl.sv
// Command sequencer behind the UART receiver: decodes framed write, read
// and ALU commands into one-cycle strobes. Every output is registered.
module rx_cmd_ctrl
    import rx_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input logic          CLK,
    input logic          RST,
    rx_cmd_ctrl_if.slave bus
);

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  byte_ok;
    logic                  byte_bad;

    // Address byte of a write frame, kept aside so RF_Address only changes
    // together with a strobe.
    logic [ADDR_WIDTH-1:0] addr_hold;

    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  alu_en;
    logic [FUN_WIDTH-1:0]  alu_fun;
    logic                  clk_gate_en;
    logic                  busy;
    logic                  cmd_err;

    assign rx_byte  = bus.RX_P_DATA;
    assign byte_ok  = bus.RX_D_VLD & ~bus.RX_ERR;
    assign byte_bad = bus.RX_D_VLD &  bus.RX_ERR;

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_next;
    end

    // Next state: one byte consumed per valid strobe, errored bytes abort.
    always_comb begin
        state_next = state;
        if (byte_bad) begin
            state_next = IDLE;
        end else if (byte_ok) begin
            case (state)
                IDLE: begin
                    case (rx_byte)
                        DATA_WIDTH'(CMD_RF_WR):   state_next = WR_ADDR;
                        DATA_WIDTH'(CMD_RF_RD):   state_next = RD_ADDR;
                        DATA_WIDTH'(CMD_ALU_OP):  state_next = OP_A;
                        DATA_WIDTH'(CMD_ALU_NOP): state_next = ALU_FN;
                        default:                  state_next = IDLE;
                    endcase
                end
                WR_ADDR: state_next = WR_DATA;
                WR_DATA: state_next = IDLE;
                RD_ADDR: state_next = IDLE;
                OP_A:    state_next = OP_B;
                OP_B:    state_next = ALU_FN;
                ALU_FN:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Registered outputs: strobes for one cycle, address/data/function held.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            addr_hold   <= '0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            address     <= '0;
            wr_data     <= '0;
            alu_en      <= 1'b0;
            alu_fun     <= '0;
            clk_gate_en <= 1'b0;
            busy        <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            alu_en      <= 1'b0;
            cmd_err     <= 1'b0;
            busy        <= (state_next != IDLE);
            clk_gate_en <= is_alu_state(state_next) || (byte_ok && state == ALU_FN);
            if (byte_bad) begin
                cmd_err <= 1'b1;
            end else if (byte_ok) begin
                case (state)
                    // A valid byte that leaves the FSM in IDLE is not an opcode.
                    IDLE:    cmd_err <= (state_next == IDLE);
                    WR_ADDR: addr_hold <= rx_byte[ADDR_WIDTH-1:0];
                    WR_DATA: begin
                        wr_en   <= 1'b1;
                        address <= addr_hold;
                        wr_data <= rx_byte;
                    end
                    RD_ADDR: begin
                        rd_en   <= 1'b1;
                        address <= rx_byte[ADDR_WIDTH-1:0];
                    end
                    OP_A: begin
                        wr_en   <= 1'b1;
                        address <= ADDR_WIDTH'(OPA_ADDR);
                        wr_data <= rx_byte;
                    end
                    OP_B: begin
                        wr_en   <= 1'b1;
                        address <= ADDR_WIDTH'(OPB_ADDR);
                        wr_data <= rx_byte;
                    end
                    ALU_FN: begin
                        alu_en  <= 1'b1;
                        alu_fun <= rx_byte[FUN_WIDTH-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.RF_WrEn     = wr_en;
    assign bus.RF_RdEn     = rd_en;
    assign bus.RF_Address  = address;
    assign bus.RF_WrData   = wr_data;
    assign bus.ALU_EN      = alu_en;
    assign bus.ALU_FUN     = alu_fun;
    assign bus.CLK_GATE_EN = clk_gate_en;
    assign bus.BUSY        = busy;
    assign bus.CMD_ERR     = cmd_err;

endmodule
